// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 7-segment driver: snapshots packed BCD digits and scans them onto one shared segment bus.
// Outputs are registered one clock behind the scan state; en=0 blanks the display and freezes the scan.
module bcd_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    err
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    function automatic logic non_bcd(input logic [4*NUM_DIGITS-1:0] v);
        non_bcd = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) non_bcd = 1'b1;
        end
    endfunction

    logic [4*NUM_DIGITS-1:0] snap;
    logic [DW-1:0]           div;
    logic [IW-1:0]           idx;

    logic                    tc;
    logic                    last;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_run;
    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic [6:0]              seg_hot;
    logic [NUM_DIGITS-1:0]   an_hot;

    assign tc   = (div == DW'(REFRESH_DIV - 1));
    assign last = (idx == IW'(NUM_DIGITS - 1));

    // A digit is blanked only when it and every digit above it are zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (snap[4*i +: 4] == 4'd0);
            blank[i] = blank_lz & zero_run;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit = snap[4*i +: 4];
                cur_blank = blank[i];
            end
        end
    end

    always_comb begin
        seg_hot = 7'h00;
        an_hot  = '0;
        if (en && !cur_blank) begin
            seg_hot = decode(cur_digit);
            an_hot  = NUM_DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap       <= '0;
            div        <= '0;
            idx        <= '0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
        end else begin
            if (load) begin
                snap <= bcd_in;
                err  <= non_bcd(bcd_in);
            end
            frame_done <= en & tc & last;
            if (en) begin
                if (tc) begin
                    div <= '0;
                    idx <= last ? '0 : idx + IW'(1);
                end else begin
                    div <= div + DW'(1);
                end
            end
            seg <= seg_hot ^ SEG_OFF;
            an  <= an_hot ^ AN_OFF;
        end
    end

endmodule
